// File: rtl/add_sub_seq.sv
// -----------------------------------------------------------------------------
// add_sub_seq
//   Multi-cycle two's-complement adder/subtractor. Operands are latched on an
//   accepted start and processed CHUNK bits per clock, LSB chunk first, over
//   N = WIDTH/CHUNK cycles. Subtraction is A + ~B + 1. The final chunk also
//   registers carry, signed overflow, optional signed saturation, and the
//   zero/negative flags of the (possibly saturated) result.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits per cycle, must divide WIDTH (CHUNK == WIDTH -> single cycle)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   start      request pulse, sampled only in IDLE
//   select     0 = A+B, 1 = A-B (latched at start)
//   sat_en     saturate signed result on overflow (latched at start)
//   a, b       operands (latched at start)
//   busy       high from the accept edge until the done edge
//   done       one-cycle pulse, result and flags valid
//   result     final result, held until the next final-chunk edge
//   carry_out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow   signed overflow of the raw sum
//   zero       result == 0 (after saturation)
//   negative   result MSB (after saturation)
// -----------------------------------------------------------------------------
module add_sub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             select,
    input  logic             sat_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_xb;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_result;
    logic             r_sat;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;
    logic [CW-1:0]    r_cnt;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_sat_val;
    logic [WIDTH-1:0] w_result_next;
    logic             w_last;
    logic             w_ovf_next;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Chunk datapath: select chunk r_cnt of both operands, add with the
    // running carry, and splice the CHUNK-bit sum into the partial result.
    always_comb begin
        w_a_chunk  = '0;
        w_b_chunk  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_cnt == CW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_xb[i*CHUNK +: CHUNK];
            end
        end
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_sum_next  = r_sum;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_cnt == CW'(i)) begin
                w_sum_next[i*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
            end
        end
    end

    assign w_last     = (r_cnt == LAST);
    // Only meaningful on the final chunk, when w_sum_next holds the full sum
    assign w_ovf_next = (r_a[WIDTH-1] == r_xb[WIDTH-1]) && (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
    // Overflow toward +inf only happens with a non-negative A, so A's sign picks the rail
    assign w_sat_val  = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_result_next = (r_sat && w_ovf_next) ? w_sat_val : w_sum_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_xb     <= '0;
            r_sum    <= '0;
            r_result <= '0;
            r_sat    <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_xb    <= b ^ {WIDTH{select}};
                        r_sat   <= sat_en;
                        r_carry <= select;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_chunk_sum[CHUNK];
                    if (w_last) begin
                        r_result <= w_result_next;
                        r_cout   <= w_chunk_sum[CHUNK];
                        r_ovf    <= w_ovf_next;
                        r_zero   <= (w_result_next == '0);
                        r_neg    <= w_result_next[WIDTH-1];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign negative  = r_neg;

endmodule

// File: tb/tb_add_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_add_sub_seq
//   Bench for add_sub_seq with two instances: WIDTH=8/CHUNK=2 (four cycles
//   per operation) and WIDTH=16/CHUNK=16 (single cycle). Expected values come
//   from an integer-arithmetic reference model of add/subtract, signed range
//   and saturation.
// -----------------------------------------------------------------------------
module tb_add_sub_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start8, sel8, sat8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, c8, v8, z8, n8;
    logic [7:0]  r8;

    logic        start16, sel16, sat16;
    logic [15:0] a16, b16;
    logic        busy16, done16, c16, v16, z16, n16;
    logic [15:0] r16;

    add_sub_seq #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .select(sel8), .sat_en(sat8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(r8),
        .carry_out(c8), .overflow(v8), .zero(z8), .negative(n8)
    );

    add_sub_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .select(sel16), .sat_en(sat16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .result(r16),
        .carry_out(c16), .overflow(v16), .zero(z16), .negative(n16)
    );

    int     n_chk  = 0;
    int     n_fail = 0;
    longint prev8  = 0;
    longint prev16 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce modulo 2^w.
    function automatic void model(input int w, input longint ua, input longint ub,
                                  input bit sel, input bit sat,
                                  output longint res, output bit c, output bit v);
        longint m, raw, sa, sb, ex;
        m   = longint'(1) << w;
        raw = sel ? (ua + (m - 1 - ub) + 1) : (ua + ub);
        c   = (raw >= m);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb  = (ub >= m / 2) ? ub - m : ub;
        ex  = sel ? (sa - sb) : (sa + sb);
        v   = (ex > m / 2 - 1) || (ex < -(m / 2));
        if (v && sat) res = (ex > 0) ? (m / 2 - 1) : (m / 2);
        else          res = raw % m;
    endfunction

    function automatic logic [15:0] get_res(input int w);
        return (w == 8) ? {8'h00, r8} : r16;
    endfunction

    // 0 busy, 1 done, 2 carry, 3 overflow, 4 zero, 5 negative
    function automatic logic get_flag(input int w, input int idx);
        logic f;
        case (idx)
            0:       f = (w == 8) ? busy8 : busy16;
            1:       f = (w == 8) ? done8 : done16;
            2:       f = (w == 8) ? c8    : c16;
            3:       f = (w == 8) ? v8    : v16;
            4:       f = (w == 8) ? z8    : z16;
            default: f = (w == 8) ? n8    : n16;
        endcase
        return f;
    endfunction

    task automatic drive(input int w, input logic st, input logic [15:0] ta,
                         input logic [15:0] tb_, input logic ts, input logic tsat);
        if (w == 8) begin
            start8 = st; a8 = ta[7:0]; b8 = tb_[7:0]; sel8 = ts; sat8 = tsat;
        end else begin
            start16 = st; a16 = ta; b16 = tb_; sel16 = ts; sat16 = tsat;
        end
    endtask

    task automatic rand_idle(input int w);
        drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One operation: accept, optional stray start during RUN (glitch = RUN
    // cycle index) and during DONE (dstart), then a short quiet watch.
    task automatic op(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic ts, input logic tsat, input int glitch,
                      input bit dstart, input string tag);
        longint m, ua, ub, er;
        bit     ec, ev;
        int     nn, lat, extra;
        bit     busy_ok;
        m  = longint'(1) << w;
        nn = (w == 8) ? 4 : 1;
        ua = longint'(ta) & (m - 1);
        ub = longint'(tb_) & (m - 1);
        model(w, ua, ub, ts, tsat, er, ec, ev);

        drive(w, 1'b1, 16'(ua), 16'(ub), ts, tsat);
        @(posedge clk); #1;
        rand_idle(w);
        chk({tag, ":busy_at_accept"}, get_flag(w, 0), 1);
        chk({tag, ":held_at_accept"}, get_res(w), (w == 8) ? prev8 : prev16);

        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            rand_idle(w);
            if (!get_flag(w, 1) && get_flag(w, 0) !== 1'b1) busy_ok = 1'b0;
            if (lat == glitch && lat < nn) drive(w, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        end while (!get_flag(w, 1) && lat < 20);

        chk({tag, ":latency"},  lat, nn);
        chk({tag, ":busy_run"}, busy_ok, 1);
        chk({tag, ":done"},     get_flag(w, 1), 1);
        chk({tag, ":busy_end"}, get_flag(w, 0), 0);
        chk({tag, ":result"},   get_res(w), er);
        chk({tag, ":carry"},    get_flag(w, 2), ec);
        chk({tag, ":overflow"}, get_flag(w, 3), ev);
        chk({tag, ":zero"},     get_flag(w, 4), (er == 0));
        chk({tag, ":negative"}, get_flag(w, 5), (er >= m / 2));
        if (w == 8) prev8 = er; else prev16 = er;

        if (dstart) drive(w, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        rand_idle(w);
        chk({tag, ":done_pulse"}, get_flag(w, 1), 0);
        chk({tag, ":idle_busy"},  get_flag(w, 0), 0);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (get_flag(w, 1) || get_flag(w, 0)) extra++;
        end
        chk({tag, ":quiet"}, extra, 0);
        chk({tag, ":held"},  get_res(w), er);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":busy8"},  busy8, 0);
        chk({tag, ":done8"},  done8, 0);
        chk({tag, ":res8"},   r8, 0);
        chk({tag, ":flags8"}, {c8, v8, z8, n8}, 0);
        chk({tag, ":busy16"}, busy16, 0);
        chk({tag, ":res16"},  r16, 0);
        chk({tag, ":flags16"}, {c16, v16, z16, n16}, 0);
    endtask

    initial begin
        int dn;
        rst = 1'b1;
        drive(8, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(16, 1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        op(8, 16'd25,   16'd17,   1'b0, 1'b0, 0, 1'b0, "add_25_17");
        chk("plan_2a", r8, 8'h2A);
        op(8, 16'd5,    16'd9,    1'b1, 1'b0, 0, 1'b0, "sub_5_9");
        chk("plan_fc", r8, 8'hFC);
        op(8, 16'd100,  16'd50,   1'b0, 1'b0, 0, 1'b0, "add_ovf");
        chk("plan_96", r8, 8'h96);
        op(8, 16'd100,  16'd50,   1'b0, 1'b1, 0, 1'b1, "add_sat");
        chk("plan_7f", r8, 8'h7F);
        op(8, 16'h80,   16'h01,   1'b1, 1'b0, 0, 1'b0, "sub_ovf");
        op(8, 16'h80,   16'h01,   1'b1, 1'b1, 0, 1'b0, "sub_sat");
        chk("plan_80", r8, 8'h80);
        op(8, 16'hFF,   16'h01,   1'b0, 1'b0, 0, 1'b0, "add_wrap");
        op(8, 16'h00,   16'h00,   1'b1, 1'b1, 0, 1'b0, "sub_zero");
        op(8, 16'd7,    16'd7,    1'b1, 1'b0, 2, 1'b1, "sub_7_7_glitch");
        chk("plan_00", r8, 8'h00);

        // Reset in the middle of RUN
        drive(8, 1'b1, 16'd25, 16'd17, 1'b0, 1'b0);
        @(posedge clk); #1;
        rand_idle(8);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dn++;
        end
        chk("mid_reset:no_done", dn, 0);
        prev8  = 0;
        prev16 = 0;

        op(8,  16'd25,   16'd17,   1'b0, 1'b0, 0, 1'b0, "rerun_25_17");
        chk("plan_rerun_2a", r8, 8'h2A);
        op(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, "w16_ovf");
        chk("plan_8000", r16, 16'h8000);
        op(16, 16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1'b0, "w16_sat");

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
               1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               bit'($urandom_range(0, 1)), "rnd8");
        end
        for (int i = 0; i < 15; i++) begin
            op(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
               0, bit'($urandom_range(0, 1)), "rnd16");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
